// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter: source encoding,
// default geometry and the round-robin helper.
package reg_wb_arbiter_pkg;

    localparam int DEF_DEPTH  = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NREG   = 8;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // On a tie, the winner is whichever source did not win last time.
    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Small write-back request FIFO holding {addr, data} pairs. Exposes the head, full and
// per-entry valid/address vectors so the top can build register-pending flags.
module wb_req_fifo
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [ADDR_W-1:0]            push_addr_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         head_valid_o,
    output logic [ADDR_W-1:0]            head_addr_o,
    output logic [DATA_W-1:0]            head_data_o,
    output logic [DEPTH-1:0]             entry_valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign head_valid_o = (count_q != '0);
    assign do_push      = push_i && !full_o;
    assign do_pop       = pop_i && head_valid_o;
    assign head_addr_o  = addr_mem_q[rd_ptr_q];
    assign head_data_o  = data_mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q and rd_ptr_q gate every use of its contents.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            addr_mem_q[wr_ptr_q] <= push_addr_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] age;
        // Distance from the read pointer; entries younger than count_q are live.
        assign age              = PTR_W'(i) - rd_ptr_q;
        assign entry_valid_o[i] = (CNT_W'(age) < count_q);
        assign entry_addr_o[i]  = addr_mem_q[i];
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register file's single write port between ALU and load write-back FIFOs
// through a round-robin arbiter and a BUSYWAIT-stallable registered write stage.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREG   = DEF_NREG
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ALU_VALID,
    input  logic [ADDR_W-1:0] ALU_ADDR,
    input  logic [DATA_W-1:0] ALU_DATA,
    output logic              ALU_READY,
    input  logic              MEM_VALID,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              MEM_READY,
    input  logic              BUSYWAIT,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN,
    output logic [NREG-1:0]   PENDING,
    output logic              IDLE
);

    logic                         alu_full, mem_full;
    logic                         alu_head_valid, mem_head_valid;
    logic [ADDR_W-1:0]            alu_head_addr, mem_head_addr;
    logic [DATA_W-1:0]            alu_head_data, mem_head_data;
    logic [DEPTH-1:0]             alu_entry_valid, mem_entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] alu_entry_addr, mem_entry_addr;
    logic                         alu_pop, mem_pop;

    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    src_e              last_grant_q, last_grant_d;

    logic              stage_free;
    logic              grant_valid;
    src_e              grant_src;
    logic [NREG-1:0]   pending;

    wb_req_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_fifo (
        .clk_i         (CLK),
        .rst_i         (RESET),
        .push_i        (ALU_VALID),
        .push_addr_i   (ALU_ADDR),
        .push_data_i   (ALU_DATA),
        .pop_i         (alu_pop),
        .full_o        (alu_full),
        .head_valid_o  (alu_head_valid),
        .head_addr_o   (alu_head_addr),
        .head_data_o   (alu_head_data),
        .entry_valid_o (alu_entry_valid),
        .entry_addr_o  (alu_entry_addr)
    );

    wb_req_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_fifo (
        .clk_i         (CLK),
        .rst_i         (RESET),
        .push_i        (MEM_VALID),
        .push_addr_i   (MEM_ADDR),
        .push_data_i   (MEM_DATA),
        .pop_i         (mem_pop),
        .full_o        (mem_full),
        .head_valid_o  (mem_head_valid),
        .head_addr_o   (mem_head_addr),
        .head_data_o   (mem_head_data),
        .entry_valid_o (mem_entry_valid),
        .entry_addr_o  (mem_entry_addr)
    );

    // The stage accepts a new entry when empty or when its current write commits this edge.
    assign stage_free = !write_q || !BUSYWAIT;

    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_ALU;
        if (stage_free) begin
            if (alu_head_valid && mem_head_valid) begin
                grant_valid = 1'b1;
                grant_src   = other_src(last_grant_q);
            end else if (alu_head_valid) begin
                grant_valid = 1'b1;
                grant_src   = SRC_ALU;
            end else if (mem_head_valid) begin
                grant_valid = 1'b1;
                grant_src   = SRC_MEM;
            end
        end
    end

    assign alu_pop = grant_valid && (grant_src == SRC_ALU);
    assign mem_pop = grant_valid && (grant_src == SRC_MEM);

    always_comb begin
        write_d      = write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        if (stage_free) begin
            write_d = grant_valid;
            if (grant_valid) begin
                last_grant_d = grant_src;
                addr_d       = (grant_src == SRC_ALU) ? alu_head_addr : mem_head_addr;
                data_d       = (grant_src == SRC_ALU) ? alu_head_data : mem_head_data;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            last_grant_q <= SRC_MEM;
        end else begin
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // A register is pending while any live FIFO entry or the write stage targets it.
    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_entry_valid[i] && (alu_entry_addr[i] == ADDR_W'(r))) pending[r] = 1'b1;
                if (mem_entry_valid[i] && (mem_entry_addr[i] == ADDR_W'(r))) pending[r] = 1'b1;
            end
            if (write_q && (addr_q == ADDR_W'(r))) pending[r] = 1'b1;
        end
    end

    assign ALU_READY = !alu_full;
    assign MEM_READY = !mem_full;
    assign WRITE     = write_q;
    assign INADDRESS = addr_q;
    assign IN        = data_q;
    assign PENDING   = pending;
    assign IDLE      = !alu_head_valid && !mem_head_valid && !write_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with a behavioural register file that commits
// on every edge where WRITE=1 and BUSYWAIT=0.
module tb_reg_wb_arbiter;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid, mem_valid, busywait;
    logic [ADDR_W-1:0] alu_addr, mem_addr;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              alu_ready, mem_ready, write, idle;
    logic [ADDR_W-1:0] inaddress;
    logic [DATA_W-1:0] in_data;
    logic [NREG-1:0]   pending;

    logic [DATA_W-1:0] rf [NREG] = '{default: '0};
    logic [DATA_W-1:0] exp_rf [NREG];
    int                commit_cnt = 0;
    int                n_tests = 0;
    int                n_fail = 0;
    int                base_commits, ready_drop, write_gaps;
    logic [ADDR_W-1:0] t6_addr;
    logic [DATA_W-1:0] t6_data;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .ALU_VALID (alu_valid),
        .ALU_ADDR  (alu_addr),
        .ALU_DATA  (alu_data),
        .ALU_READY (alu_ready),
        .MEM_VALID (mem_valid),
        .MEM_ADDR  (mem_addr),
        .MEM_DATA  (mem_data),
        .MEM_READY (mem_ready),
        .BUSYWAIT  (busywait),
        .WRITE     (write),
        .INADDRESS (inaddress),
        .IN        (in_data),
        .PENDING   (pending),
        .IDLE      (idle)
    );

    always @(posedge clk) begin
        if (write && !busywait) begin
            rf[inaddress] <= in_data;
            commit_cnt    <= commit_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        alu_valid = v;
        alu_addr  = a;
        alu_data  = d;
    endtask

    task automatic set_mem(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_valid = v;
        mem_addr  = a;
        mem_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        busywait = 1'b0;
        set_alu(0, '0, '0);
        set_mem(0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_write", write, 0);
        check("rst_addr", inaddress, 0);
        check("rst_in", in_data, 0);
        check("rst_pending", pending, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_mem_ready", mem_ready, 1);
        check("rst_idle", idle, 1);
        rst = 1'b0;
        step();

        // 1: single ALU push, two-edge latency to commit
        set_alu(1, 3'd3, 8'h5A);
        step();
        set_alu(0, '0, '0);
        check("t1_pend_queued", pending, 8'h08);
        check("t1_write_early", write, 0);
        step();
        check("t1_write", write, 1);
        check("t1_addr", inaddress, 3);
        check("t1_data", in_data, 8'h5A);
        step();
        check("t1_rf3", rf[3], 8'h5A);
        check("t1_pend_clear", pending, 0);
        check("t1_idle", idle, 1);

        // 2a: tie after an ALU grant -> MEM first
        set_alu(1, 3'd5, 8'h55);
        set_mem(1, 3'd6, 8'h66);
        step();
        set_alu(0, '0, '0);
        set_mem(0, '0, '0);
        step();
        check("t2a_first_addr", inaddress, 6);
        check("t2a_first_data", in_data, 8'h66);
        step();
        check("t2a_second_addr", inaddress, 5);
        check("t2a_second_write", write, 1);
        step();
        check("t2a_write_done", write, 0);
        check("t2a_rf5", rf[5], 8'h55);
        check("t2a_rf6", rf[6], 8'h66);

        // lone MEM grant moves last-grant to MEM
        set_mem(1, 3'd7, 8'h77);
        step();
        set_mem(0, '0, '0);
        step();
        step();
        check("t2_rf7", rf[7], 8'h77);

        // 2b: tie after a MEM grant -> ALU first
        set_alu(1, 3'd1, 8'h11);
        set_mem(1, 3'd2, 8'h22);
        step();
        set_alu(0, '0, '0);
        set_mem(0, '0, '0);
        step();
        check("t2b_first_addr", inaddress, 1);
        step();
        check("t2b_second_addr", inaddress, 2);
        step();
        check("t2b_rf1", rf[1], 8'h11);
        check("t2b_rf2", rf[2], 8'h22);

        // 3: BUSYWAIT holds the stage for 5 edges
        set_alu(1, 3'd4, 8'h44);
        step();
        set_alu(0, '0, '0);
        step();
        check("t3_loaded_addr", inaddress, 4);
        busywait = 1'b1;
        set_alu(1, 3'd0, 8'h0A);
        step();
        set_alu(0, '0, '0);
        repeat (4) step();
        check("t3_hold_write", write, 1);
        check("t3_hold_addr", inaddress, 4);
        check("t3_hold_data", in_data, 8'h44);
        check("t3_rf4_untouched", rf[4], 8'h00);
        check("t3_pending", pending, 8'h11);
        busywait = 1'b0;
        step();
        check("t3_rf4", rf[4], 8'h44);
        check("t3_next_addr", inaddress, 0);
        check("t3_next_data", in_data, 8'h0A);
        step();
        check("t3_rf0", rf[0], 8'h0A);
        check("t3_idle", idle, 1);

        // 4: FIFO fills behind a stalled stage; third push ignored
        busywait = 1'b1;
        set_mem(1, 3'd3, 8'h33);
        step();
        set_mem(0, '0, '0);
        step();
        check("t4_stage_addr", inaddress, 3);
        set_alu(1, 3'd1, 8'hA1);
        step();
        check("t4_ready_after1", alu_ready, 1);
        set_alu(1, 3'd2, 8'hB2);
        step();
        check("t4_ready_after2", alu_ready, 0);
        set_alu(1, 3'd5, 8'hC5);
        step();
        check("t4_ready_after3", alu_ready, 0);
        check("t4_pending", pending, 8'h0E);
        set_alu(0, '0, '0);
        busywait = 1'b0;
        step();
        check("t4_rf3", rf[3], 8'h33);
        check("t4_order1_addr", inaddress, 1);
        check("t4_order1_data", in_data, 8'hA1);
        step();
        check("t4_order2_addr", inaddress, 2);
        check("t4_order2_data", in_data, 8'hB2);
        step();
        check("t4_write_done", write, 0);
        check("t4_rf1", rf[1], 8'hA1);
        check("t4_rf2", rf[2], 8'hB2);
        check("t4_rf5_unchanged", rf[5], 8'h55);

        // 5: asynchronous reset with a staged write and two queued entries
        busywait = 1'b1;
        set_mem(1, 3'd1, 8'hF1);
        step();
        set_mem(0, '0, '0);
        step();
        set_alu(1, 3'd2, 8'hF2);
        set_mem(1, 3'd3, 8'hF3);
        step();
        set_alu(0, '0, '0);
        set_mem(0, '0, '0);
        check("t5_pending_before", pending, 8'h0E);
        check("t5_idle_before", idle, 0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_write_async", write, 0);
        check("t5_pending_async", pending, 0);
        check("t5_idle_async", idle, 1);
        check("t5_addr_async", inaddress, 0);
        check("t5_ready_async", alu_ready, 1);
        busywait = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        check("t5_rf1_kept", rf[1], 8'hA1);
        check("t5_rf2_kept", rf[2], 8'hB2);
        check("t5_rf3_kept", rf[3], 8'h33);
        check("t5_idle_after", idle, 1);

        // 6: alternating pushes, one commit per cycle
        for (int r = 0; r < NREG; r++) exp_rf[r] = rf[r];
        base_commits = commit_cnt;
        ready_drop   = 0;
        write_gaps   = 0;
        for (int i = 0; i < 20; i++) begin
            t6_addr = ADDR_W'(i);
            t6_data = DATA_W'(8'h80 + i);
            if (i % 2 == 0) begin
                set_alu(1, t6_addr, t6_data);
                set_mem(0, '0, '0);
            end else begin
                set_alu(0, '0, '0);
                set_mem(1, t6_addr, t6_data);
            end
            exp_rf[t6_addr] = t6_data;
            step();
            if (!alu_ready || !mem_ready) ready_drop++;
            if (i >= 1 && !write) write_gaps++;
        end
        set_alu(0, '0, '0);
        set_mem(0, '0, '0);
        step();
        step();
        check("t6_ready_drop", ready_drop, 0);
        check("t6_write_gaps", write_gaps, 0);
        check("t6_commits", commit_cnt - base_commits, 20);
        for (int r = 0; r < NREG; r++) check("t6_rf", rf[r], exp_rf[r]);
        check("t6_idle", idle, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
